// File: rtl/dmem_pipe.sv
// dmem_pipe: byte-addressed RV32I data memory with a single-outstanding
// request handshake and a configurable load latency.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ready for a request; stores commit on the accept edge
// RD_WAIT | load accepted and data captured; counting down the latency
// RESP    | one-cycle response pulse, no request accepted
module dmem_pipe #(
  parameter int MEM_SIZE_KB  = 1,
  parameter int READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_dataIn,
  output logic        o_rsp_valid,
  output logic [31:0] o_dataOut,
  output logic        o_misaligned
);

  localparam int DEPTH = MEM_SIZE_KB * 1024;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_RESP    = 2'd2;

  localparam logic [1:0] LAT_M1 = 2'(READ_LATENCY - 1);

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic          rdy_en;
  logic [31:0]   data_q;
  logic          err_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;
  logic          accept;
  logic          err;
  logic [31:0]   ld_data;

  // Address bits above the capacity are ignored; the memory wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = &{1'b0, i_addr[31:AW]};

  // rdy_en keeps ready low throughout reset and for the cycle until the
  // first edge after release.
  assign o_req_ready = rdy_en && (state == S_IDLE);
  assign accept      = i_req_valid && o_req_ready;

  assign a0 = i_addr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Decode size/sign code and alignment; illegal codes are reported as misaligned.
  always_comb begin
    err = 1'b1;
    if (i_we) begin
      case (i_funct3)
        3'b000:  err = 1'b0;
        3'b001:  err = i_addr[0];
        3'b010:  err = |i_addr[1:0];
        default: err = 1'b1;
      endcase
    end else begin
      case (i_funct3)
        3'b000, 3'b100: err = 1'b0;
        3'b001, 3'b101: err = i_addr[0];
        3'b010:         err = |i_addr[1:0];
        default:        err = 1'b1;
      endcase
    end
  end

  // Assemble the load result from little-endian bytes; zero for errors and stores.
  always_comb begin
    ld_data = 32'd0;
    if (!i_we && !err) begin
      case (i_funct3)
        3'b000:  ld_data = {{24{b0[7]}}, b0};
        3'b001:  ld_data = {{16{b1[7]}}, b1, b0};
        3'b010:  ld_data = {b3, b2, b1, b0};
        3'b100:  ld_data = {24'd0, b0};
        3'b101:  ld_data = {16'd0, b1, b0};
        default: ld_data = 32'd0;
      endcase
    end
  end

  // Memory array: not reset, written only by an accepted legal store.
  always_ff @(posedge i_clk) begin
    if (accept && i_we && !err) begin
      mem[a0] <= i_dataIn[7:0];
      if (i_funct3 != 3'b000) begin
        mem[a1] <= i_dataIn[15:8];
      end
      if (i_funct3 == 3'b010) begin
        mem[a2] <= i_dataIn[23:16];
        mem[a3] <= i_dataIn[31:24];
      end
    end
  end

  // Request FSM; load data is captured at accept so later stores cannot alter it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= S_IDLE;
      cnt    <= 2'd0;
      rdy_en <= 1'b0;
      data_q <= 32'd0;
      err_q  <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            data_q <= i_we ? 32'd0 : ld_data;
            err_q  <= err;
            if (i_we || (READ_LATENCY == 1)) begin
              state <= S_RESP;
            end else begin
              state <= S_RD_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        S_RD_WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) begin
            state <= S_RESP;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid  = (state == S_RESP);
  assign o_dataOut    = o_rsp_valid ? data_q : 32'd0;
  assign o_misaligned = o_rsp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_dmem_pipe.sv
// tb_dmem_pipe: directed bench for dmem_pipe with a latency-1 instance (u1)
// and a latency-3 instance (u3) sharing the clock and request fields.
module tb_dmem_pipe;

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        v1, v3;
  logic        we_s;
  logic [31:0] addr_s;
  logic [2:0]  f3_s;
  logic [31:0] din_s;

  logic        ready1, rv1, mis1;
  logic [31:0] dout1;
  logic        ready3, rv3, mis3;
  logic [31:0] dout3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_pipe #(.MEM_SIZE_KB(1), .READ_LATENCY(1)) u1 (
    .i_clk(clk), .i_rst_n(rst1), .i_req_valid(v1), .o_req_ready(ready1),
    .i_we(we_s), .i_addr(addr_s), .i_funct3(f3_s), .i_dataIn(din_s),
    .o_rsp_valid(rv1), .o_dataOut(dout1), .o_misaligned(mis1)
  );

  dmem_pipe #(.MEM_SIZE_KB(1), .READ_LATENCY(3)) u3 (
    .i_clk(clk), .i_rst_n(rst3), .i_req_valid(v3), .o_req_ready(ready3),
    .i_we(we_s), .i_addr(addr_s), .i_funct3(f3_s), .i_dataIn(din_s),
    .o_rsp_valid(rv3), .o_dataOut(dout3), .o_misaligned(mis3)
  );

  // Issue one request to instance sel (0: u1, 1: u3) and collect the response.
  // lat is the number of falling edges after the accept edge until the pulse
  // is seen (-1 on timeout); stay/idle_* are sampled one cycle after the pulse.
  task automatic issue(input int sel, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] din,
                       output int lat, output logic [31:0] dout, output logic mis,
                       output logic stay, output logic [31:0] idle_dout,
                       output logic idle_mis);
    @(negedge clk);
    we_s = we; addr_s = addr; f3_s = f3; din_s = din;
    if (sel == 0) v1 = 1'b1; else v3 = 1'b1;
    @(posedge clk);
    #1;
    v1 = 1'b0; v3 = 1'b0;
    lat = -1; dout = 32'd0; mis = 1'b0; stay = 1'b0; idle_dout = 32'd0; idle_mis = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if ((sel == 0) ? rv1 : rv3) begin
        lat  = k;
        dout = (sel == 0) ? dout1 : dout3;
        mis  = (sel == 0) ? mis1 : mis3;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      stay      = (sel == 0) ? rv1 : rv3;
      idle_dout = (sel == 0) ? dout1 : dout3;
      idle_mis  = (sel == 0) ? mis1 : mis3;
    end
  endtask

  task automatic test_reset;
    rst1 = 1'b1; rst3 = 1'b1; v1 = 1'b0; v3 = 1'b0;
    we_s = 1'b0; addr_s = 32'd0; f3_s = 3'd0; din_s = 32'd0;
    #1;
    rst1 = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (ready1 !== 1'b0 || rv1 !== 1'b0 || dout1 !== 32'd0 || mis1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_outputs: ready=%b rsp=%b dout=%h mis=%b, want 0 0 0 0", ready1, rv1, dout1, mis1);
    end
    vectors++;
    if (ready3 !== 1'b0 || rv3 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_outputs_l3: ready=%b rsp=%b, want 0 0", ready3, rv3);
    end
    #1;
    rst1 = 1'b1; rst3 = 1'b1;
    #1;
    vectors++;
    if (ready1 !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_release_ready_early: got %b want 0", ready1);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (ready1 !== 1'b1 || ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_release_ready: got %b/%b want 1/1", ready1, ready3);
    end
  endtask

  task automatic test_basic;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    issue(0, 1'b1, 32'h8, 3'b010, 32'h0000000A, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 1 || d !== 32'd0 || m !== 1'b0 || st !== 1'b0) begin
      miscompares++;
      $display("FAIL sw_basic: lat=%0d dout=%h mis=%b stay=%b, want 1 0 0 0", lat, d, m, st);
    end
    issue(0, 1'b0, 32'h8, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 1 || d !== 32'h0000000A || m !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_basic: lat=%0d dout=%h mis=%b, want 1 0000000a 0", lat, d, m);
    end
    vectors++;
    if (st !== 1'b0 || idd !== 32'd0) begin
      miscompares++;
      $display("FAIL lw_basic_after: rsp=%b dout=%h, want 0 00000000", st, idd);
    end
  endtask

  task automatic test_wrap;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    issue(0, 1'b1, 32'h33242344, 3'b010, 32'h000000E9, lat, d, m, st, idd, idm);
    issue(0, 1'b0, 32'h00000344, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 1 || d !== 32'h000000E9 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_wrap: lat=%0d dout=%h mis=%b, want 1 000000e9 0", lat, d, m);
    end
  endtask

  task automatic test_subword;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    logic [31:0] la [6] = '{32'h103, 32'h103, 32'h100, 32'h102, 32'h102, 32'h101};
    logic [2:0]  lf [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001, 3'b100};
    logic [31:0] le [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01,
                            32'h000080FF, 32'hFFFF80FF, 32'h0000007F};
    issue(0, 1'b1, 32'h100, 3'b010, 32'h80FF7F01, lat, d, m, st, idd, idm);
    for (int i = 0; i < 6; i++) begin
      issue(0, 1'b0, la[i], lf[i], 32'd0, lat, d, m, st, idd, idm);
      vectors++;
      if (d !== le[i] || m !== 1'b0 || lat !== 1) begin
        miscompares++;
        $display("FAIL subword_load[%0d]: dout=%h mis=%b lat=%0d, want %h 0 1", i, d, m, lat, le[i]);
      end
    end
    issue(0, 1'b1, 32'h101, 3'b000, 32'hAAAAAA55, lat, d, m, st, idd, idm);
    issue(0, 1'b0, 32'h100, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (d !== 32'h80FF5501) begin
      miscompares++;
      $display("FAIL sb_merge: dout=%h want 80ff5501", d);
    end
    issue(0, 1'b1, 32'h102, 3'b001, 32'hCCCC1234, lat, d, m, st, idd, idm);
    issue(0, 1'b0, 32'h100, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (d !== 32'h12345501) begin
      miscompares++;
      $display("FAIL sh_merge: dout=%h want 12345501", d);
    end
  endtask

  task automatic test_errors;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    logic        ew [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] ea [6] = '{32'h101, 32'h102, 32'h100, 32'h100, 32'h101, 32'h102};
    logic [2:0]  ef [6] = '{3'b001, 3'b010, 3'b011, 3'b011, 3'b101, 3'b010};
    logic [31:0] ed [6] = '{32'h0000BEEF, 32'hFFFFFFFF, 32'h00000000, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 6; i++) begin
      issue(0, ew[i], ea[i], ef[i], ed[i], lat, d, m, st, idd, idm);
      vectors++;
      if (m !== 1'b1 || d !== 32'd0 || lat !== 1) begin
        miscompares++;
        $display("FAIL err_rsp[%0d]: mis=%b dout=%h lat=%0d, want 1 00000000 1", i, m, d, lat);
      end
      vectors++;
      if (idm !== 1'b0 || st !== 1'b0) begin
        miscompares++;
        $display("FAIL err_after[%0d]: mis=%b rsp=%b, want 0 0", i, idm, st);
      end
    end
    issue(0, 1'b0, 32'h100, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (d !== 32'h12345501 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL err_no_write: dout=%h mis=%b, want 12345501 0", d, m);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    we_s = 1'b0; addr_s = 32'h8; f3_s = 3'b010; v1 = 1'b1;
    @(negedge clk);
    vectors++;
    if (rv1 !== 1'b1 || ready1 !== 1'b0 || dout1 !== 32'h0000000A) begin
      miscompares++;
      $display("FAIL b2b_first: rsp=%b ready=%b dout=%h, want 1 0 0000000a", rv1, ready1, dout1);
    end
    addr_s = 32'h344;
    @(negedge clk);
    vectors++;
    if (rv1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gap: rsp=%b ready=%b, want 0 1", rv1, ready1);
    end
    @(negedge clk);
    v1 = 1'b0;
    vectors++;
    if (rv1 !== 1'b1 || dout1 !== 32'h000000E9) begin
      miscompares++;
      $display("FAIL b2b_second: rsp=%b dout=%h, want 1 000000e9", rv1, dout1);
    end
    @(negedge clk);
    vectors++;
    if (rv1 !== 1'b0 || ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_end: rsp=%b ready=%b, want 0 1", rv1, ready1);
    end
  endtask

  task automatic test_latency3;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    issue(1, 1'b1, 32'h20, 3'b010, 32'hCAFEF00D, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 1 || m !== 1'b0) begin
      miscompares++;
      $display("FAIL l3_store: lat=%0d mis=%b, want 1 0", lat, m);
    end
    @(negedge clk);
    we_s = 1'b0; addr_s = 32'h20; f3_s = 3'b010; din_s = 32'd0; v3 = 1'b1;
    @(posedge clk);
    #1;
    // A second request held during the wait must be ignored.
    we_s = 1'b1; din_s = 32'h11111111;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (ready3 !== 1'b0 || rv3 !== (k == 3)) begin
        miscompares++;
        $display("FAIL l3_wait[%0d]: ready=%b rsp=%b, want 0 %0d", k, ready3, rv3, (k == 3));
      end
      if (k == 3) begin
        vectors++;
        if (dout3 !== 32'hCAFEF00D || mis3 !== 1'b0) begin
          miscompares++;
          $display("FAIL l3_data: dout=%h mis=%b, want cafef00d 0", dout3, mis3);
        end
        v3 = 1'b0;
      end
    end
    @(negedge clk);
    vectors++;
    if (rv3 !== 1'b0 || ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL l3_end: rsp=%b ready=%b, want 0 1", rv3, ready3);
    end
    issue(1, 1'b0, 32'h20, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 3 || d !== 32'hCAFEF00D) begin
      miscompares++;
      $display("FAIL l3_ignored: lat=%0d dout=%h, want 3 cafef00d", lat, d);
    end
  endtask

  task automatic test_reset_abort;
    int lat; logic [31:0] d, idd; logic m, st, idm;
    logic seen;
    issue(1, 1'b1, 32'h40, 3'b010, 32'h00005A5A, lat, d, m, st, idd, idm);
    @(negedge clk);
    we_s = 1'b0; addr_s = 32'h40; f3_s = 3'b010; v3 = 1'b1;
    @(posedge clk);
    #1;
    v3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    vectors++;
    if (rv3 !== 1'b0 || ready3 !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_in_reset: rsp=%b ready=%b, want 0 0", rv3, ready3);
    end
    repeat (2) @(negedge clk);
    rst3 = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv3) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || ready3 !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_no_rsp: rsp_seen=%b ready=%b, want 0 1", seen, ready3);
    end
    issue(1, 1'b0, 32'h40, 3'b010, 32'd0, lat, d, m, st, idd, idm);
    vectors++;
    if (lat !== 3 || d !== 32'h00005A5A || m !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_mem_kept: lat=%0d dout=%h mis=%b, want 3 00005a5a 0", lat, d, m);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_subword;
    test_errors;
    test_back_to_back;
    test_latency3;
    test_reset_abort;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
